poly1305_block_mul: RTL and testbench

- Multiply stage of the Poly1305 MAC datapath, directly upstream of the mod-(2^130-5) reducer.
- Per message block: adds the 130-bit accumulator to the padded block, clamps r, and forms the product (acc + block) * r_clamped.
- The product is emitted on a 258-bit bus that feeds the reducer's value_in. The reducer's 130-bit value_out returns as the next acc_in.
- Digit-serial shift-add multiplier: area is traded for latency.

---
 rtl/poly1305_block_mul.sv | 137 +++++++++++++
 tb/tb_poly1305_block_mul.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_block_mul.sv
// rtl/poly1305_block_mul.sv - Poly1305 multiply stage: (acc + padded block) * clamp(r), digit-serial
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   start             request, accepted only when busy=0
//   acc_in[129:0]     current accumulator
//   msg_in[127:0]     message block, little-endian bytes
//   r_in[127:0]       raw r key half, clamped internally
//   msg_bytes[4:0]    (POLY1305_PARTIAL_BLOCK_EN only) valid bytes in msg_in, 1..16
//   product_out[257:0] (acc + block) * r_clamped, valid from done, held until next completion
//   busy              high while the multiplier iterates
//   done              one-cycle pulse when product_out is updated
//
// Optional feature macro: POLY1305_PARTIAL_BLOCK_EN (short final block with moved pad bit).

module poly1305_block_mul #(
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [129:0] acc_in,
    input  logic [127:0] msg_in,
    input  logic [127:0] r_in,
`ifdef POLY1305_PARTIAL_BLOCK_EN
    input  logic [4:0]   msg_bytes,
`endif
    output logic [257:0] product_out,
    output logic         busy,
    output logic         done
);

    localparam int N     = 128 / DIGIT_W;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int PP_W  = 131 + DIGIT_W;
    localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [130:0]       sum_q, sum_d;
    logic [127:0]       r_sh_q, r_sh_d;
    logic [257:0]       p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [257:0]       product_q, product_d;
    logic               done_q, done_d;

    logic [128:0]       block;
    logic [DIGIT_W-1:0] digit;
    logic [PP_W-1:0]    pp;
    logic [257:0]       p_next;

`ifdef POLY1305_PARTIAL_BLOCK_EN
    logic [4:0]   nbytes;
    logic [127:0] msg_masked;

    // Bytes beyond the valid length are zeroed and the pad bit sits just above the last valid byte.
    always_comb begin
        nbytes = ((msg_bytes == 5'd0) || (msg_bytes > 5'd16)) ? 5'd16 : msg_bytes;
        msg_masked = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < nbytes) begin
                msg_masked[8*i +: 8] = msg_in[8*i +: 8];
            end
        end
        block = {1'b0, msg_masked} + (129'd1 << {nbytes, 3'b000});
    end
`else
    always_comb begin
        block = {1'b1, msg_in};
    end
`endif

    // One MSB-first Horner step: shift previous partial product up one digit and add sum * digit.
    always_comb begin
        digit  = r_sh_q[127 -: DIGIT_W];
        pp     = {{DIGIT_W{1'b0}}, sum_q} * {{131{1'b0}}, digit};
        p_next = (p_q << DIGIT_W) + {{(258 - PP_W){1'b0}}, pp};
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        r_sh_d    = r_sh_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = {1'b0, acc_in} + {2'b00, block};
                    r_sh_d  = r_in & R_CLAMP;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                p_d    = p_next;
                r_sh_d = r_sh_q << DIGIT_W;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    product_d = p_next;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sum_q     <= '0;
            r_sh_q    <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            r_sh_q    <= r_sh_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product_out = product_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = done_q;

endmodule

// File: tb/tb_poly1305_block_mul.sv
// tb/tb_poly1305_block_mul.sv - self-checking bench for poly1305_block_mul (DIGIT_W = 1, 8, 32)

module tb_poly1305_block_mul;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [129:0] acc_in = '0;
    logic [127:0] msg_in = '0;
    logic [127:0] r_in = '0;
`ifdef POLY1305_PARTIAL_BLOCK_EN
    logic [4:0]   msg_bytes = 5'd16;
`endif
    logic [257:0] prod1, prod8, prod32;
    logic         busy1, busy8, busy32;
    logic         done1, done8, done32;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    poly1305_block_mul #(.DIGIT_W(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .acc_in(acc_in), .msg_in(msg_in), .r_in(r_in),
`ifdef POLY1305_PARTIAL_BLOCK_EN
        .msg_bytes(msg_bytes),
`endif
        .product_out(prod1), .busy(busy1), .done(done1));

    poly1305_block_mul #(.DIGIT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .acc_in(acc_in), .msg_in(msg_in), .r_in(r_in),
`ifdef POLY1305_PARTIAL_BLOCK_EN
        .msg_bytes(msg_bytes),
`endif
        .product_out(prod8), .busy(busy8), .done(done8));

    poly1305_block_mul #(.DIGIT_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start), .acc_in(acc_in), .msg_in(msg_in), .r_in(r_in),
`ifdef POLY1305_PARTIAL_BLOCK_EN
        .msg_bytes(msg_bytes),
`endif
        .product_out(prod32), .busy(busy32), .done(done32));

    // Reference: (acc + (msg masked to nb bytes) + 2^(8*nb)) * (r & clamp), plain wide arithmetic.
    function automatic logic [257:0] ref_prod(input logic [129:0] a, input logic [127:0] m,
                                              input logic [127:0] r, input int nb);
        logic [257:0] blk, acc, rc, mm;
        int n;
        n = (nb < 1 || nb > 16) ? 16 : nb;
        mm = '0;
        for (int i = 0; i < n; i++) mm[8*i +: 8] = m[8*i +: 8];
        blk = mm + (258'd1 << (8 * n));
        acc = 258'(a);
        rc = 258'(r & 128'h0ffffffc0ffffffc0ffffffc0fffffff);
        return (acc + blk) * rc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_idle();
        for (int i = 0; i < 300 && (busy1 || busy8 || busy32); i++) tick();
    endtask

    // Launch one operation and wait for the DIGIT_W=8 instance; lat=-1 if done never arrives.
    task automatic run_op8(input logic [129:0] a, input logic [127:0] m, input logic [127:0] r,
                           output logic [257:0] prod, output int lat);
        acc_in = a; msg_in = m; r_in = r; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        prod = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done8) begin
                lat = c;
                prod = prod8;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        total++; if (prod8 !== 258'd0) begin bad++; $display("FAIL reset_product got=%h exp=0", prod8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat = 0, busy_cnt, done_cnt = 0;
        wait_all_idle();
        acc_in = '0; msg_in = '0; r_in = 128'd1; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
        end
        total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d exp=16", lat); end
        total++; if (busy_cnt !== 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=16", busy_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        total++; if (prod8 !== (258'd1 << 128)) begin bad++; $display("FAIL basic_product got=%h exp=%h", prod8, 258'd1 << 128); end
    endtask

    task automatic test_clamp();
        logic [257:0] p, exp;
        int lat;
        exp = 258'(128'h0ffffffc0ffffffc0ffffffc0fffffff) << 128;
        run_op8('0, '0, {128{1'b1}}, p, lat);
        total++; if (p !== exp) begin bad++; $display("FAIL clamp_product got=%h exp=%h lat=%0d", p, exp, lat); end
    endtask

    task automatic test_max();
        logic [257:0] p, exp;
        int lat;
        exp = (258'd1 << 130) + (258'd1 << 129) - 258'd2;
        run_op8({130{1'b1}}, {128{1'b1}}, 128'd1, p, lat);
        total++; if (p !== exp) begin bad++; $display("FAIL max_product got=%h exp=%h lat=%0d", p, exp, lat); end
        total++; if (p[257:131] !== '0) begin bad++; $display("FAIL max_upper_bits got=%h exp=0", p[257:131]); end
    endtask

    task automatic test_random();
        logic [129:0] a;
        logic [127:0] m, r;
        logic [257:0] exp, g1, g8, g32;
        int l1, l8, l32, nb;
        for (int v = 0; v < 300; v++) begin
            wait_all_idle();
            a = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            m = {$urandom(), $urandom(), $urandom(), $urandom()};
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (v == 0) a = {130{1'b1}};
            nb = 16;
`ifdef POLY1305_PARTIAL_BLOCK_EN
            msg_bytes = 5'($urandom_range(0, 31));
            nb = int'(msg_bytes);
`endif
            exp = ref_prod(a, m, r, nb);
            acc_in = a; msg_in = m; r_in = r; start = 1'b1;
            tick();
            start = 1'b0;
            l1 = -1; l8 = -1; l32 = -1;
            g1 = '0; g8 = '0; g32 = '0;
            for (int c = 1; c <= 140 && l1 < 0; c++) begin
                tick();
                if (done1 && l1 < 0) begin l1 = c; g1 = prod1; end
                if (done8 && l8 < 0) begin l8 = c; g8 = prod8; end
                if (done32 && l32 < 0) begin l32 = c; g32 = prod32; end
            end
            total++; if (g1 !== exp) begin bad++; $display("FAIL rand_d1_product v=%0d got=%h exp=%h", v, g1, exp); end
            total++; if (g8 !== exp) begin bad++; $display("FAIL rand_d8_product v=%0d got=%h exp=%h", v, g8, exp); end
            total++; if (g32 !== exp) begin bad++; $display("FAIL rand_d32_product v=%0d got=%h exp=%h", v, g32, exp); end
            total++; if (l1 !== 128) begin bad++; $display("FAIL rand_d1_latency v=%0d got=%0d exp=128", v, l1); end
            total++; if (l8 !== 16) begin bad++; $display("FAIL rand_d8_latency v=%0d got=%0d exp=16", v, l8); end
            total++; if (l32 !== 4) begin bad++; $display("FAIL rand_d32_latency v=%0d got=%0d exp=4", v, l32); end
        end
`ifdef POLY1305_PARTIAL_BLOCK_EN
        msg_bytes = 5'd16;
`endif
    endtask

    task automatic test_back_to_back();
        logic [129:0] a1, a2;
        logic [127:0] m1, m2, r1, r2;
        logic [257:0] e1, e2, held;
        int lat1 = -1, lat2 = -1;
        wait_all_idle();
        a1 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        m1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        r1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        a2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        m2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        r2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        e1 = ref_prod(a1, m1, r1, 16);
        e2 = ref_prod(a2, m2, r2, 16);
        acc_in = a1; msg_in = m1; r_in = r1; start = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 3) begin acc_in = a2; msg_in = m2; r_in = r2; end
            if (done8) begin lat1 = c; break; end
        end
        total++; if (lat1 !== 16) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=16", lat1); end
        total++; if (prod8 !== e1) begin bad++; $display("FAIL b2b_first_product got=%h exp=%h", prod8, e1); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_busy_at_done got=%b exp=0", busy8); end
        tick();
        start = 1'b0;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_reaccept_busy got=%b exp=1", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL b2b_done_width got=%b exp=0", done8); end
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done8) begin lat2 = c; break; end
        end
        total++; if (lat2 !== 16) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=16", lat2); end
        total++; if (prod8 !== e2) begin bad++; $display("FAIL b2b_second_product got=%h exp=%h", prod8, e2); end
        held = prod8;
        acc_in = a1; msg_in = m1; r_in = r1;
        tick(); tick(); tick();
        total++; if (prod8 !== e2) begin bad++; $display("FAIL hold_product got=%h exp=%h", prod8, e2); end
        total++; if (held !== e2) begin bad++; $display("FAIL hold_capture got=%h exp=%h", held, e2); end
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        wait_all_idle();
        acc_in = 130'h3; msg_in = 128'h5; r_in = 128'h7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy8); end
        total++; if (prod8 !== 258'd0) begin bad++; $display("FAIL midreset_product got=%h exp=0", prod8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done8); end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (done8 || done1 || done32) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", done_seen); end
        total++; if (prod8 !== 258'd0) begin bad++; $display("FAIL midreset_product_after got=%h exp=0", prod8); end
    endtask

`ifdef POLY1305_PARTIAL_BLOCK_EN
    task automatic test_partial_block();
        logic [257:0] p, exp;
        logic [127:0] m;
        int lat;
        wait_all_idle();
        msg_bytes = 5'd1;
        run_op8('0, {128{1'b1}}, 128'd1, p, lat);
        total++; if (p !== 258'h1ff) begin bad++; $display("FAIL partial_1byte got=%h exp=1ff", p); end
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp = ref_prod(130'h12345, m, 128'h1111, 16);
        msg_bytes = 5'd16;
        run_op8(130'h12345, m, 128'h1111, p, lat);
        total++; if (p !== exp) begin bad++; $display("FAIL partial_16bytes got=%h exp=%h", p, exp); end
        msg_bytes = 5'd0;
        run_op8(130'h12345, m, 128'h1111, p, lat);
        total++; if (p !== exp) begin bad++; $display("FAIL partial_0bytes got=%h exp=%h", p, exp); end
        msg_bytes = 5'd5;
        exp = ref_prod(130'h12345, m, 128'h1111, 5);
        run_op8(130'h12345, m, 128'h1111, p, lat);
        total++; if (p !== exp) begin bad++; $display("FAIL partial_5bytes got=%h exp=%h", p, exp); end
        msg_bytes = 5'd16;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_max();
        test_back_to_back();
        test_reset_mid_run();
`ifdef POLY1305_PARTIAL_BLOCK_EN
        test_partial_block();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
